// File: rtl/alu_muldiv_pkg.sv
// Shared types for the iterative multiply/divide engine.
// Optional feature macro: ALU_MULDIV_CANCEL_EN (adds the cancel input).
package alu_muldiv_pkg;

  typedef struct packed {
    logic clk;
    logic rst;
  } ctrl_t;

  typedef enum logic [3:0] {
    FUNC_ADD  = 4'd0,
    FUNC_ADDU = 4'd1,
    FUNC_SUB  = 4'd2,
    FUNC_SUBU = 4'd3,
    FUNC_AND  = 4'd4,
    FUNC_OR   = 4'd5,
    FUNC_XOR  = 4'd6,
    FUNC_NOR  = 4'd7,
    FUNC_SLT  = 4'd8,
    FUNC_SLTU = 4'd9,
    FUNC_MULU = 4'd10,
    FUNC_MULS = 4'd11,
    FUNC_DIVU = 4'd12,
    FUNC_DIVS = 4'd13,
    FUNC_SLL  = 4'd14,
    FUNC_SRL  = 4'd15
  } alu_func_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_RUN  = 3'd2;
  localparam state_t ST_FIX  = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  function automatic logic is_muldiv(alu_func_e f);
    return f inside {FUNC_MULU, FUNC_MULS,
                     FUNC_DIVU, FUNC_DIVS};
  endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One radix-2 multiply/divide step plus the shared negator
// used for operand magnitudes and final sign correction.
import alu_muldiv_pkg::*;

module alu_muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] acc_hi,
  input  logic [DATA_W-1:0] acc_lo,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] acc_hi_n,
  output logic [DATA_W-1:0] acc_lo_n,
  output logic              q_bit,
  input  logic              neg_split,
  input  logic [DATA_W-1:0] neg_in_hi,
  input  logic [DATA_W-1:0] neg_in_lo,
  output logic [DATA_W-1:0] neg_hi,
  output logic [DATA_W-1:0] neg_lo
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] rem_sh;
  logic [DATA_W:0] diff;
  logic            hi_cin;

  always_comb begin
    sum      = {1'b0, acc_hi} + {1'b0, operand};
    rem_sh   = {acc_hi, acc_lo[DATA_W-1]};
    diff     = rem_sh - {1'b0, operand};
    q_bit    = 1'b0;
    acc_hi_n = acc_hi;
    acc_lo_n = acc_lo;
    if (is_div) begin
      // rem < divisor keeps diff in range, so bit W is the borrow
      q_bit    = ~diff[DATA_W];
      acc_hi_n = q_bit ? diff[DATA_W-1:0]
                       : rem_sh[DATA_W-1:0];
      acc_lo_n = {acc_lo[DATA_W-2:0], 1'b0};
    end else if (acc_lo[0]) begin
      {acc_hi_n, acc_lo_n} = {sum, acc_lo[DATA_W-1:1]};
    end else begin
      {acc_hi_n, acc_lo_n} =
        {1'b0, acc_hi, acc_lo[DATA_W-1:1]};
    end
  end

  // split: two independent W-bit negations; else one 2W negation
  always_comb begin
    hi_cin = neg_split ? 1'b1 : (neg_in_lo == '0);
    neg_lo = ~neg_in_lo + DATA_W'(1);
    neg_hi = ~neg_in_hi + DATA_W'(hi_cin);
  end

endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU engine feeding the HI/LO stage.
// Define ALU_MULDIV_CANCEL_EN to add the cancel (flush) input.
import alu_muldiv_pkg::*;

module alu_muldiv_iter #(
  parameter int DATA_W = 32
) (
  input  ctrl_t             ctrl,
  input  logic              start,
  input  alu_func_e         func,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo,
  output logic              div_zero
`ifdef ALU_MULDIV_CANCEL_EN
  ,
  input  logic              cancel
`endif
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic clk;
  logic rst;
  assign clk = ctrl.clk;
  assign rst = ctrl.rst;

  logic kill;
`ifdef ALU_MULDIV_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W-1:0] acc_lo;
  logic              is_div;
  logic              is_sgn;
  logic              neg_q;
  logic              neg_r;

  logic [DATA_W-1:0] step_hi;
  logic [DATA_W-1:0] step_lo;
  logic              q_bit;
  logic              neg_split;
  logic [DATA_W-1:0] neg_in_hi;
  logic [DATA_W-1:0] neg_in_lo;
  logic [DATA_W-1:0] neg_hi;
  logic [DATA_W-1:0] neg_lo;
  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;
  logic [DATA_W-1:0] fix_hi;
  logic [DATA_W-1:0] fix_lo;
  logic              accept;
  logic              last;
  logic              op2_zero;

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign accept   = (state == ST_IDLE) && start
                    && is_muldiv(func);
  assign last     = (cnt == CW'(DATA_W-1));
  assign op2_zero = (op2 == '0);

  // negator serves LOAD (operand abs) and FIX (sign fix)
  always_comb begin
    neg_split = 1'b1;
    neg_in_hi = op1;
    neg_in_lo = op2;
    if (state == ST_FIX) begin
      neg_split = is_div;
      neg_in_hi = acc_hi;
      neg_in_lo = acc_lo;
    end
  end

  alu_muldiv_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .is_div   (is_div),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .operand  (b_mag),
    .acc_hi_n (step_hi),
    .acc_lo_n (step_lo),
    .q_bit    (q_bit),
    .neg_split(neg_split),
    .neg_in_hi(neg_in_hi),
    .neg_in_lo(neg_in_lo),
    .neg_hi   (neg_hi),
    .neg_lo   (neg_lo)
  );

  assign mag1 = (is_sgn && op1[DATA_W-1]) ? neg_hi : op1;
  assign mag2 = (is_sgn && op2[DATA_W-1]) ? neg_lo : op2;

  always_comb begin
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    unique case (1'b1)
      is_div && op2_zero: begin
        fix_hi = op1;
        fix_lo = '1;
      end
      is_div && !op2_zero: begin
        if (neg_q) fix_lo = neg_lo;
        if (neg_r) fix_hi = neg_hi;
      end
      !is_div: begin
        if (neg_q) begin
          fix_hi = neg_hi;
          fix_lo = neg_lo;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op1      <= '0;
      op2      <= '0;
      b_mag    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      is_div   <= 1'b0;
      is_sgn   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      res_hi   <= '0;
      res_lo   <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_LOAD;
            op1    <= data1;
            op2    <= data2;
            is_div <= func inside {FUNC_DIVU, FUNC_DIVS};
            is_sgn <= func inside {FUNC_MULS, FUNC_DIVS};
          end
        end
        ST_LOAD: begin
          if (kill) begin
            state <= ST_IDLE;
          end else begin
            state    <= ST_RUN;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= is_div ? mag1 : mag2;
            b_mag    <= is_div ? mag2 : mag1;
            neg_q    <= is_sgn
                        & (op1[DATA_W-1] ^ op2[DATA_W-1]);
            neg_r    <= is_sgn & op1[DATA_W-1];
            div_zero <= 1'b0;
          end
        end
        ST_RUN: begin
          if (kill) begin
            state <= ST_IDLE;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo | DATA_W'(q_bit);
            cnt    <= cnt + CW'(1);
            if (last) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (kill) begin
            state <= ST_IDLE;
          end else begin
            state    <= ST_DONE;
            res_hi   <= fix_hi;
            res_lo   <= fix_lo;
            div_zero <= is_div && op2_zero;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Directed-vector bench for alu_muldiv_iter (DATA_W=32).
// Cancel scenario is exercised when ALU_MULDIV_CANCEL_EN is defined.
import alu_muldiv_pkg::*;

module tb_alu_muldiv_iter;

  localparam int W = 32;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  ctrl_t       ctrl;
  logic        start = 1'b0;
  alu_func_e   func  = FUNC_ADDU;
  logic [W-1:0] data1 = '0;
  logic [W-1:0] data2 = '0;
  logic        busy;
  logic        done;
  logic [W-1:0] res_hi;
  logic [W-1:0] res_lo;
  logic        div_zero;
`ifdef ALU_MULDIV_CANCEL_EN
  logic        cancel = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  assign ctrl = '{clk: clk, rst: rst};

  always #5 clk = ~clk;

  alu_muldiv_iter #(
    .DATA_W(W)
  ) dut (
`ifdef ALU_MULDIV_CANCEL_EN
    .cancel  (cancel),
`endif
    .ctrl    (ctrl),
    .start   (start),
    .func    (func),
    .data1   (data1),
    .data2   (data2),
    .busy    (busy),
    .done    (done),
    .res_hi  (res_hi),
    .res_lo  (res_lo),
    .div_zero(div_zero)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h",
               tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input alu_func_e f,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] eh,
                        input logic [W-1:0] el,
                        input logic ez,
                        input bit poke);
    int n;
    bit all_busy;
    func  = f;
    data1 = a;
    data2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    func  = FUNC_MULU;
    data1 = 32'h5A5A_5A5A;
    data2 = 32'h0000_0003;
    n = 0;
    all_busy = 1'b1;
    while (!done && n < 60) begin
      if (!busy) all_busy = 1'b0;
      if (poke && n == 4) begin
        start = 1'b1;
        func  = FUNC_DIVU;
        data1 = 32'd9;
        data2 = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'(W + 2));
    chk({tag, " busy"}, 64'(all_busy), 64'(1));
    chk({tag, " res_hi"}, 64'(res_hi), 64'(eh));
    chk({tag, " res_lo"}, 64'(res_lo), 64'(el));
    chk({tag, " div_zero"}, 64'(div_zero), 64'(ez));
    @(posedge clk);
    #1;
    chk({tag, " done_1cyc"}, 64'(done), 64'(0));
    chk({tag, " idle"}, 64'(busy), 64'(0));
    chk({tag, " hold_lo"}, 64'(res_lo), 64'(el));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst res_hi", 64'(res_hi), 64'(0));
    chk("rst res_lo", 64'(res_lo), 64'(0));
    chk("rst div_zero", 64'(div_zero), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("mulu_max", FUNC_MULU, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFE,
           32'h0000_0001, 1'b0, 1'b1);
    run_op("muls_m3x5", FUNC_MULS, 32'hFFFF_FFFD,
           32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
           1'b0, 1'b0);
    run_op("divs_m7d2", FUNC_DIVS, 32'hFFFF_FFF9,
           32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           1'b0, 1'b0);
    run_op("divu_100d7", FUNC_DIVU, 32'd100, 32'd7,
           32'd2, 32'd14, 1'b0, 1'b0);
    run_op("divu_5d0", FUNC_DIVU, 32'd5, 32'd0,
           32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("mulu_2x3", FUNC_MULU, 32'd2, 32'd3,
           32'd0, 32'd6, 1'b0, 1'b0);
    run_op("divs_ovf", FUNC_DIVS, 32'h8000_0000,
           32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
           1'b0, 1'b0);
    run_op("muls_min2", FUNC_MULS, 32'h8000_0000,
           32'h8000_0000, 32'h4000_0000, 32'd0,
           1'b0, 1'b0);
    run_op("divs_7dm2", FUNC_DIVS, 32'd7,
           32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD,
           1'b0, 1'b0);
    run_op("divu_big", FUNC_DIVU, 32'hFFFF_FFFF,
           32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0, 1'b0);
    run_op("divs_m7d0", FUNC_DIVS, 32'hFFFF_FFF9,
           32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
           1'b1, 1'b0);

    func  = FUNC_ADDU;
    data1 = 32'd1;
    data2 = 32'd1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("addu busy", 64'(busy), 64'(0));
    end
    start = 1'b0;
    chk("addu res_lo", 64'(res_lo), 64'hFFFF_FFFF);
    chk("addu div_zero", 64'(div_zero), 64'(1));

    func  = FUNC_MULU;
    data1 = 32'd3;
    data2 = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrun busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("arst busy", 64'(busy), 64'(0));
    chk("arst done", 64'(done), 64'(0));
    chk("arst res_hi", 64'(res_hi), 64'(0));
    chk("arst res_lo", 64'(res_lo), 64'(0));
    chk("arst div_zero", 64'(div_zero), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst idle", 64'(busy), 64'(0));

    run_op("divu_again", FUNC_DIVU, 32'd100, 32'd7,
           32'd2, 32'd14, 1'b0, 1'b0);

`ifdef ALU_MULDIV_CANCEL_EN
    begin
      bit saw_done;
      func  = FUNC_MULU;
      data1 = 32'd3;
      data2 = 32'd7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      cancel = 1'b1;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      chk("cancel idle", 64'(busy), 64'(0));
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (done) saw_done = 1'b1;
      end
      chk("cancel no_done", 64'(saw_done), 64'(0));
      chk("cancel res_hi", 64'(res_hi), 64'd2);
      chk("cancel res_lo", 64'(res_lo), 64'd14);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
